// File: rtl/node_pkg.sv
// Shared node types and constants for the stripe feeder: FSM states,
// descriptor layout and the stripe-index helper used by the arbiter.
package node_pkg;

    localparam int NUM_STRIPES  = 8;
    localparam int DATA_WIDTH   = 16;
    localparam int BLOCK_WIDTH  = 8 * DATA_WIDTH;
    localparam int TAG_WIDTH    = 12;
    localparam int INSTR_WIDTH  = 7;
    localparam int DESC_DEPTH   = 4;
    localparam int STRIPE_IDX_W = $clog2(NUM_STRIPES);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} feeder_state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tagA;
        logic [TAG_WIDTH-1:0]   tagB;
        logic [TAG_WIDTH-1:0]   strideA;
        logic [TAG_WIDTH-1:0]   strideB;
        logic [TAG_WIDTH-1:0]   iter_lim;
        logic [INSTR_WIDTH-1:0] instr;
    } stripe_desc_t;

    // Next stripe index, wrapping at NUM_STRIPES (not necessarily a power of two).
    function automatic logic [STRIPE_IDX_W-1:0] next_idx(input logic [STRIPE_IDX_W-1:0] idx);
        if (int'(idx) == NUM_STRIPES - 1)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/stripe_feeder_if.sv
// Stripe tag/data request bundle. The feeder (responder) takes the slave
// modport; the router/core and stripe-array side takes the master modport.
interface stripe_feeder_if;
    import node_pkg::*;

    logic [NUM_STRIPES-1:0] req;
    logic [NUM_STRIPES-1:0] grant;
    logic                   desc_valid;
    logic                   desc_ready;
    logic [TAG_WIDTH-1:0]   desc_tagA, desc_tagB, desc_strideA, desc_strideB, desc_iter_lim;
    logic [INSTR_WIDTH-1:0] desc_instr;
    logic                   data_valid;
    logic                   data_ready;
    logic [BLOCK_WIDTH-1:0] d0_IN, d1_IN;
    logic                   tag_write;
    logic                   data_strobe;
    logic [TAG_WIDTH-1:0]   tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT, iter_lim_OUT;
    logic [INSTR_WIDTH-1:0] instr_OUT;
    logic [BLOCK_WIDTH-1:0] d0_OUT, d1_OUT;
    logic                   busy;

    modport slave (
        input  req, desc_valid, desc_tagA, desc_tagB, desc_strideA, desc_strideB,
               desc_iter_lim, desc_instr, data_valid, d0_IN, d1_IN,
        output grant, desc_ready, data_ready, tag_write, data_strobe, tagA_OUT, tagB_OUT,
               strideA_OUT, strideB_OUT, iter_lim_OUT, instr_OUT, d0_OUT, d1_OUT, busy
    );

    modport master (
        output req, desc_valid, desc_tagA, desc_tagB, desc_strideA, desc_strideB,
               desc_iter_lim, desc_instr, data_valid, d0_IN, d1_IN,
        input  grant, desc_ready, data_ready, tag_write, data_strobe, tagA_OUT, tagB_OUT,
               strideA_OUT, strideB_OUT, iter_lim_OUT, instr_OUT, d0_OUT, d1_OUT, busy
    );

endinterface

// File: rtl/stripe_feeder_desc_fifo.sv
// Small synchronous descriptor FIFO (depth a power of two), async reset.
// Head entry is visible combinationally so the feeder can broadcast it in LOAD.
module desc_fifo
    import node_pkg::*;
#(
    parameter int DEPTH = DESC_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  stripe_desc_t i_wdata,
    input  logic         i_pop,
    output stripe_desc_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    stripe_desc_t   r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/stripe_feeder.sv
// Stripe feeder: arbitrates stripe requests, broadcasts one queued descriptor per
// grant, then streams tagged operand blocks. STRIPE_FEEDER_FIXED_PRIO_EN selects
// lowest-index-wins arbitration instead of round-robin.
module stripe_feeder
    import node_pkg::*;
#(
    parameter int FIFO_DEPTH = DESC_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    stripe_feeder_if.slave  bus
);
    feeder_state_t           r_state, w_state_next;
    stripe_desc_t            w_wdata, w_head;
    logic                    w_full, w_empty, w_push, w_pop, w_accept;
    logic                    w_arb_found;
    logic [STRIPE_IDX_W-1:0] w_arb_idx;

    logic [NUM_STRIPES-1:0]  r_grant;
    logic                    r_tag_write, r_data_strobe;
    logic [TAG_WIDTH-1:0]    r_tagA_out, r_tagB_out, r_strideA_out, r_strideB_out, r_iter_lim_out;
    logic [INSTR_WIDTH-1:0]  r_instr_out;
    logic [BLOCK_WIDTH-1:0]  r_d0_out, r_d1_out;
    logic [TAG_WIDTH-1:0]    r_cur_tagA, r_cur_tagB, r_beat_cnt;
`ifndef STRIPE_FEEDER_FIXED_PRIO_EN
    logic [STRIPE_IDX_W-1:0] r_rr_ptr, r_grant_idx;
`endif

    assign w_wdata.tagA     = bus.desc_tagA;
    assign w_wdata.tagB     = bus.desc_tagB;
    assign w_wdata.strideA  = bus.desc_strideA;
    assign w_wdata.strideB  = bus.desc_strideB;
    assign w_wdata.iter_lim = bus.desc_iter_lim;
    assign w_wdata.instr    = bus.desc_instr;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign bus.desc_ready = !w_full || w_pop;
    assign w_push         = bus.desc_valid && bus.desc_ready;
    assign w_accept       = (r_state == STREAM) && bus.data_valid;

    desc_fifo #(.DEPTH(FIFO_DEPTH)) u_desc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        int j;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        j           = 0;
`ifdef STRIPE_FEEDER_FIXED_PRIO_EN
        for (int i = NUM_STRIPES - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = STRIPE_IDX_W'(i);
            end
        end
`else
        for (int i = 0; i < NUM_STRIPES; i++) begin
            j = (int'(r_rr_ptr) + i) % NUM_STRIPES;
            if (!w_arb_found && bus.req[j]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = STRIPE_IDX_W'(j);
            end
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE:    if (!w_empty && w_arb_found) w_state_next = LOAD;
            LOAD: begin
                w_pop        = 1'b1;
                w_state_next = (w_head.iter_lim == '0) ? DONE : STREAM;
            end
            STREAM:  if (w_accept && (r_beat_cnt + TAG_WIDTH'(1) == r_iter_lim_out)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant        <= '0;
            r_tag_write    <= 1'b0;
            r_data_strobe  <= 1'b0;
            r_tagA_out     <= '0;
            r_tagB_out     <= '0;
            r_strideA_out  <= '0;
            r_strideB_out  <= '0;
            r_iter_lim_out <= '0;
            r_instr_out    <= '0;
            r_d0_out       <= '0;
            r_d1_out       <= '0;
            r_cur_tagA     <= '0;
            r_cur_tagB     <= '0;
            r_beat_cnt     <= '0;
`ifndef STRIPE_FEEDER_FIXED_PRIO_EN
            r_rr_ptr       <= '0;
            r_grant_idx    <= '0;
`endif
        end else begin
            r_tag_write   <= (r_state == LOAD);
            r_data_strobe <= w_accept;
            case (r_state)
                IDLE: if (w_state_next == LOAD) begin
                    r_grant     <= NUM_STRIPES'(1) << w_arb_idx;
`ifndef STRIPE_FEEDER_FIXED_PRIO_EN
                    r_grant_idx <= w_arb_idx;
`endif
                end
                LOAD: begin
                    r_tagA_out     <= w_head.tagA;
                    r_tagB_out     <= w_head.tagB;
                    r_strideA_out  <= w_head.strideA;
                    r_strideB_out  <= w_head.strideB;
                    r_iter_lim_out <= w_head.iter_lim;
                    r_instr_out    <= w_head.instr;
                    r_cur_tagA     <= w_head.tagA;
                    r_cur_tagB     <= w_head.tagB;
                    r_beat_cnt     <= '0;
                end
                STREAM: if (w_accept) begin
                    r_tagA_out <= r_cur_tagA;
                    r_tagB_out <= r_cur_tagB;
                    r_cur_tagA <= r_cur_tagA + r_strideA_out;
                    r_cur_tagB <= r_cur_tagB + r_strideB_out;
                    r_d0_out   <= bus.d0_IN;
                    r_d1_out   <= bus.d1_IN;
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
                DONE: begin
                    r_grant  <= '0;
`ifndef STRIPE_FEEDER_FIXED_PRIO_EN
                    r_rr_ptr <= next_idx(r_grant_idx);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.data_ready   = w_accept;
    assign bus.tag_write    = r_tag_write;
    assign bus.data_strobe  = r_data_strobe;
    assign bus.tagA_OUT     = r_tagA_out;
    assign bus.tagB_OUT     = r_tagB_out;
    assign bus.strideA_OUT  = r_strideA_out;
    assign bus.strideB_OUT  = r_strideB_out;
    assign bus.iter_lim_OUT = r_iter_lim_out;
    assign bus.instr_OUT    = r_instr_out;
    assign bus.d0_OUT       = r_d0_out;
    assign bus.d1_OUT       = r_d1_out;
    assign bus.busy         = (r_state != IDLE);

endmodule
